// File: rtl/ex_stage_md.sv
// Execute stage with ALU, fixed-latency multiplier and iterative restoring divider.
// Divider states: IDLE | no divide active;  BUSY | one quotient bit per cycle;  FIX | apply signs;  DONE | result ready for MEM
module ex_stage_md #(
  parameter int DATA_W  = 32,
  parameter int DEST_W  = 5,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              ex_allow_in,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [DATA_W-1:0] in_rkd,
  input  logic [3:0]        in_op,
  input  logic              in_mem_we,
  input  logic              in_res_from_mem,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_gr_we,
  input  logic              mem_allow_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_rkd,
  output logic              out_mem_we,
  output logic              out_res_from_mem,
  output logic              out_gr_we,
  output logic [DEST_W-1:0] out_dest
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_FIX, DIV_DONE} div_state_t;

  div_state_t        div_state, div_state_nx;
  logic              ex_valid, ready_go, accept, taken;
  logic [3:0]        ex_op;
  logic [DATA_W-1:0] ex_src1, ex_src2;
  logic [2:0]        mul_cnt;
  logic              in_is_mul, in_is_div, ex_is_mul, ex_is_div;
  logic              div_load, div_step, div_fix, div_ready;
  logic              in_signed, a_neg, b_neg;
  logic [CNT_W-1:0]  div_cnt;
  logic [DATA_W-1:0] div_quo, div_rem, div_dvs;
  logic              q_neg, r_neg;
  logic [DATA_W:0]   rem_sh, rem_diff;
  logic              step_ge;
  logic [DATA_W-1:0] step_rem;
  logic [2*DATA_W-1:0] mul_a, mul_b, prod;
  logic              mulh_signed;

  assign in_is_mul = (in_op >= 4'd7) && (in_op <= 4'd9);
  assign in_is_div = (in_op >= 4'd10) && (in_op <= 4'd13);
  assign ex_is_mul = (ex_op >= 4'd7) && (ex_op <= 4'd9);
  assign ex_is_div = (ex_op >= 4'd10) && (ex_op <= 4'd13);

  assign ex_allow_in = ~ex_valid | (ready_go & mem_allow_in);
  assign out_valid   = ex_valid & ready_go;
  assign accept      = in_valid & ex_allow_in & ~flush;
  assign taken       = out_valid & mem_allow_in;

  always_comb begin
    ready_go = 1'b1;
    if (ex_is_div)      ready_go = div_ready;
    else if (ex_is_mul) ready_go = (mul_cnt == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid         <= 1'b0;
      ex_op            <= 4'd0;
      ex_src1          <= '0;
      ex_src2          <= '0;
      out_pc           <= '0;
      out_rkd          <= '0;
      out_mem_we       <= 1'b0;
      out_res_from_mem <= 1'b0;
      out_gr_we        <= 1'b0;
      out_dest         <= '0;
    end else begin
      if (flush)            ex_valid <= 1'b0;
      else if (ex_allow_in) ex_valid <= in_valid;
      if (accept) begin
        ex_op            <= in_op;
        ex_src1          <= in_src1;
        ex_src2          <= in_src2;
        out_pc           <= in_pc;
        out_rkd          <= in_rkd;
        out_mem_we       <= in_mem_we;
        out_res_from_mem <= in_res_from_mem;
        out_gr_we        <= in_gr_we;
        out_dest         <= in_dest;
      end
    end
  end

  // Multiply result is combinational; the counter only delays ready_go.
  always_ff @(posedge clk) begin
    if (reset || flush)     mul_cnt <= 3'd0;
    else if (accept)        mul_cnt <= in_is_mul ? 3'(MUL_LAT) : 3'd0;
    else if (mul_cnt != 0)  mul_cnt <= mul_cnt - 3'd1;
  end

  // Only MULH needs sign extension; the low half is the same for both.
  assign mulh_signed = (ex_op == 4'd8);
  assign mul_a = {{DATA_W{mulh_signed & ex_src1[DATA_W-1]}}, ex_src1};
  assign mul_b = {{DATA_W{mulh_signed & ex_src2[DATA_W-1]}}, ex_src2};
  assign prod  = mul_a * mul_b;

  always_ff @(posedge clk) begin
    if (reset) div_state <= DIV_IDLE;
    else       div_state <= div_state_nx;
  end

  always_comb begin
    div_state_nx = div_state;
    if (flush)
      div_state_nx = DIV_IDLE;
    else if (accept && in_is_div)
      div_state_nx = DIV_BUSY;
    else begin
      case (div_state)
        DIV_BUSY: if (div_cnt == CNT_W'(1)) div_state_nx = DIV_FIX;
        DIV_FIX:  div_state_nx = DIV_DONE;
        DIV_DONE: if (taken) div_state_nx = DIV_IDLE;
        default:  div_state_nx = div_state;
      endcase
    end
  end

  always_comb begin
    div_load  = accept & in_is_div;
    div_step  = (div_state == DIV_BUSY);
    div_fix   = (div_state == DIV_FIX);
    div_ready = (div_state == DIV_DONE);
  end

  assign in_signed = (in_op == 4'd10) || (in_op == 4'd12);
  assign a_neg     = in_signed & in_src1[DATA_W-1];
  assign b_neg     = in_signed & in_src2[DATA_W-1];

  // Remainder stays below the divisor, so bit DATA_W of the difference is the borrow.
  assign rem_sh   = {div_rem, div_quo[DATA_W-1]};
  assign rem_diff = rem_sh - {1'b0, div_dvs};
  assign step_ge  = ~rem_diff[DATA_W];
  assign step_rem = step_ge ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      div_quo <= '0;
      div_rem <= '0;
      div_dvs <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else if (flush) begin
      div_cnt <= '0;
    end else if (div_load) begin
      div_cnt <= CNT_W'(DATA_W);
      div_quo <= a_neg ? -in_src1 : in_src1;
      div_rem <= '0;
      div_dvs <= b_neg ? -in_src2 : in_src2;
      // A zero divisor naturally yields all-ones / dividend when left unsigned.
      q_neg   <= (a_neg ^ b_neg) & (in_src2 != '0);
      r_neg   <= a_neg;
    end else if (div_step) begin
      div_cnt <= div_cnt - CNT_W'(1);
      div_rem <= step_rem;
      div_quo <= {div_quo[DATA_W-2:0], step_ge};
    end else if (div_fix) begin
      div_quo <= q_neg ? -div_quo : div_quo;
      div_rem <= r_neg ? -div_rem : div_rem;
    end
  end

  always_comb begin
    out_result = ex_src1 + ex_src2;
    case (ex_op)
      4'd1:         out_result = ex_src1 - ex_src2;
      4'd2:         out_result = ex_src1 & ex_src2;
      4'd3:         out_result = ex_src1 | ex_src2;
      4'd4:         out_result = ex_src1 ^ ex_src2;
      4'd5:         out_result = {{(DATA_W-1){1'b0}}, $signed(ex_src1) < $signed(ex_src2)};
      4'd6:         out_result = {{(DATA_W-1){1'b0}}, ex_src1 < ex_src2};
      4'd7:         out_result = prod[DATA_W-1:0];
      4'd8, 4'd9:   out_result = prod[2*DATA_W-1:DATA_W];
      4'd10, 4'd11: out_result = div_quo;
      4'd12, 4'd13: out_result = div_rem;
      default:      out_result = ex_src1 + ex_src2;
    endcase
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: ALU, stall, multiply latency, divide corners, flush and reset.
module tb_ex_stage_md;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLTU = 4'd6, OP_MUL = 4'd7,
                         OP_MULH = 4'd8, OP_MULHU = 4'd9, OP_DIV = 4'd10, OP_DIVU = 4'd11,
                         OP_MOD = 4'd12, OP_MODU = 4'd13;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, ex_allow_in;
  logic [31:0] in_pc, in_src1, in_src2, in_rkd;
  logic [3:0]  in_op;
  logic        in_mem_we, in_res_from_mem, in_gr_we, mem_allow_in;
  logic [4:0]  in_dest;
  logic        out_valid, out_mem_we, out_res_from_mem, out_gr_we;
  logic [31:0] out_pc, out_result, out_rkd;
  logic [4:0]  out_dest;

  int n_assert = 0;
  int n_fail   = 0;
  int bad;

  ex_stage_md #(.DATA_W(32), .DEST_W(5), .MUL_LAT(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .ex_allow_in(ex_allow_in),
    .in_pc(in_pc), .in_src1(in_src1), .in_src2(in_src2), .in_rkd(in_rkd), .in_op(in_op),
    .in_mem_we(in_mem_we), .in_res_from_mem(in_res_from_mem), .in_dest(in_dest),
    .in_gr_we(in_gr_we), .mem_allow_in(mem_allow_in), .out_valid(out_valid),
    .out_pc(out_pc), .out_result(out_result), .out_rkd(out_rkd), .out_mem_we(out_mem_we),
    .out_res_from_mem(out_res_from_mem), .out_gr_we(out_gr_we), .out_dest(out_dest)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [4:0] dest);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_pc = pc; in_dest = dest;
    in_rkd = 32'h0; in_mem_we = 1'b0; in_res_from_mem = 1'b0; in_gr_we = 1'b1;
  endtask

  task automatic mul_case(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    drive(op, a, b, 32'h600, 5'd6);
    tick();
    in_valid = 1'b0;
    chk({tag, "_v0"}, out_valid, 0);
    tick();
    chk({tag, "_v1"}, out_valid, 0);
    tick();
    chk({tag, "_v2"}, out_valid, 1);
    chk({tag, "_res"}, out_result, exp);
    tick();
  endtask

  // Leaves the result presented; the next call's accept coincides with MEM taking it.
  task automatic div_case(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    drive(op, a, b, 32'h700, 5'd10);
    tick();
    in_valid = 1'b0;
    bad = 0;
    for (int k = 0; k <= 32; k++) begin
      if (out_valid !== 1'b0 || ex_allow_in !== 1'b0) bad++;
      tick();
    end
    chk({tag, "_early"}, bad, 0);
    chk({tag, "_v33"}, out_valid, 1);
    chk({tag, "_res"}, out_result, exp);
  endtask

  logic [3:0]  alu_op  [7] = '{OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, 4'd15};
  logic [31:0] alu_a   [7] = '{32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2};
  logic [31:0] alu_b   [7] = '{32'd7, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
                               32'd1, 32'd1, 32'd3};
  logic [31:0] alu_exp [7] = '{32'hFFFFFFFE, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0,
                               32'd1, 32'd0, 32'd5};

  initial begin
    reset = 1'b1; flush = 1'b0; mem_allow_in = 1'b1;
    drive(OP_SUB, 32'd123, 32'd45, 32'h40, 5'd9);
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_dest", out_dest, 0);
    chk("rst_allow", ex_allow_in, 1);
    in_valid = 1'b0;
    reset = 1'b0;
    tick();

    drive(OP_ADD, 32'h7FFFFFFF, 32'd1, 32'h100, 5'd3);
    tick();
    chk("add_valid", out_valid, 1);
    chk("add_res", out_result, 32'h80000000);
    chk("add_pc", out_pc, 32'h100);
    chk("add_allow", ex_allow_in, 1);
    drive(OP_ADD, 32'd5, 32'd6, 32'h104, 5'd4);
    tick();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_res", out_result, 32'd11);
    chk("b2b_pc", out_pc, 32'h104);
    chk("b2b_dest", out_dest, 32'd4);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);

    mem_allow_in = 1'b0;
    drive(OP_ADD, 32'd3, 32'd4, 32'h200, 5'd7);
    in_rkd = 32'hDEADBEEF; in_mem_we = 1'b1;
    tick();
    drive(OP_XOR, 32'hF0F0, 32'hFF00, 32'h204, 5'd8);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_res", out_result, 32'd7);
      chk("stall_pc", out_pc, 32'h200);
      chk("stall_rkd", out_rkd, 32'hDEADBEEF);
      chk("stall_we", out_mem_we, 1);
      chk("stall_allow", ex_allow_in, 0);
      tick();
    end
    mem_allow_in = 1'b1;
    #1;
    chk("unstall_allow", ex_allow_in, 1);
    tick();
    chk("unstall_res", out_result, 32'h00000FF0);
    chk("unstall_pc", out_pc, 32'h204);
    chk("unstall_we", out_mem_we, 0);

    for (int i = 0; i < 7; i++) begin
      drive(alu_op[i], alu_a[i], alu_b[i], 32'h300 + 32'(4 * i), 5'd1);
      tick();
      chk("alu_valid", out_valid, 1);
      chk($sformatf("alu_op%0d", alu_op[i]), out_result, alu_exp[i]);
    end
    in_valid = 1'b0;
    tick();

    mul_case("mulh", OP_MULH, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
    mul_case("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'd2, 32'h00000001);
    mul_case("mul", OP_MUL, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);

    div_case("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    div_case("mod_m7_2", OP_MOD, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    div_case("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
    div_case("mod_7_m2", OP_MOD, 32'd7, 32'hFFFFFFFE, 32'd1);
    div_case("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF);
    div_case("modu_5_0", OP_MODU, 32'd5, 32'd0, 32'd5);
    div_case("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    div_case("mod_ovf", OP_MOD, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    div_case("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF);
    in_valid = 1'b0;
    tick();
    chk("div_drain", out_valid, 0);

    drive(OP_DIV, 32'd100, 32'd7, 32'h800, 5'd9);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    drive(OP_ADD, 32'd9, 32'd9, 32'h900, 5'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_allow", ex_allow_in, 1);
    drive(OP_ADD, 32'd1, 32'd1, 32'h804, 5'd2);
    tick();
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_res", out_result, 32'd2);
    chk("post_flush_pc", out_pc, 32'h804);
    in_valid = 1'b0;
    bad = 0;
    repeat (40) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    chk("flush_ghost", bad, 0);

    drive(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hA00, 5'd5);
    in_rkd = 32'h1234; in_res_from_mem = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_result", out_result, 0);
    chk("mid_rst_pc", out_pc, 0);
    chk("mid_rst_rkd", out_rkd, 0);
    chk("mid_rst_dest", out_dest, 0);
    chk("mid_rst_gr_we", out_gr_we, 0);
    chk("mid_rst_ld", out_res_from_mem, 0);
    reset = 1'b0;
    bad = 0;
    repeat (40) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    chk("rst_ghost", bad, 0);
    chk("rst_allow", ex_allow_in, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
